// File: rtl/gnn_pkg.sv
// Shared constants, state encoding and feature-slice helper for the GNN MAC scheduler.
package gnn_pkg;
    localparam int NODES = 4;
    localparam int FEATS = 4;
    localparam int XW    = 5;
    localparam int AW    = XW + 2;
    localparam int OW    = 17;

    typedef logic [2:0] sched_state_t;
    localparam sched_state_t ST_IDLE  = 3'd0;
    localparam sched_state_t ST_AGGR  = 3'd1;
    localparam sched_state_t ST_ISSUE = 3'd2;
    localparam sched_state_t ST_WAIT  = 3'd3;
    localparam sched_state_t ST_STORE = 3'd4;
    localparam sched_state_t ST_DONE  = 3'd5;

    typedef logic [NODES*FEATS*XW-1:0] feat_vec_t;

    function automatic logic [XW-1:0] feat_of(input feat_vec_t f, input int node, input int k);
        return f[(node*FEATS+k)*XW +: XW];
    endfunction
endpackage

// File: rtl/gnn_mac_scheduler_if.sv
// Bundle between the scheduler and the shared MAC datapath.
interface gnn_mac_scheduler_if;
    import gnn_pkg::*;

    // mac_in_ready is a one-cycle issue strobe qualifying mac_x0..3; the MAC answers with
    // independent one-cycle result strobes, no back-pressure, accepted only while waiting.
    logic [AW-1:0] mac_x0;
    logic [AW-1:0] mac_x1;
    logic [AW-1:0] mac_x2;
    logic [AW-1:0] mac_x3;
    logic          mac_in_ready;
    logic [OW-1:0] mac_out0;
    logic [OW-1:0] mac_out1;
    logic          mac_out0_ready;
    logic          mac_out1_ready;

    modport master (
        output mac_x0, mac_x1, mac_x2, mac_x3, mac_in_ready,
        input  mac_out0, mac_out1, mac_out0_ready, mac_out1_ready
    );

    modport slave (
        input  mac_x0, mac_x1, mac_x2, mac_x3, mac_in_ready,
        output mac_out0, mac_out1, mac_out0_ready, mac_out1_ready
    );
endinterface

// File: rtl/gnn_aggr.sv
// Combinational neighbour sum for one adjacency row over the snapshot features.
module gnn_aggr
    import gnn_pkg::*;
(
    input  feat_vec_t                  feats,
    input  logic [NODES-1:0]           row,
    output logic [FEATS-1:0][AW-1:0]   aggr
);
    // Four 5-bit terms peak at 124, so AW bits never overflow.
    always_comb begin
        aggr = '0;
        for (int k = 0; k < FEATS; k++) begin
            for (int j = 0; j < NODES; j++) begin
                if (row[j]) aggr[k] = aggr[k] + AW'(feat_of(feats, j, k));
            end
        end
    end
endmodule

// File: rtl/gnn_mac_scheduler.sv
// Time-multiplexes one MAC across the graph nodes: aggregate, issue, wait for both
// result strobes, store per-node results, then pulse done.
module gnn_mac_scheduler
    import gnn_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  feat_vec_t              feat_in,
    input  logic [NODES*NODES-1:0] adj,
    gnn_mac_scheduler_if.master    mac,
    output logic [OW-1:0]          out0_node0,
    output logic [OW-1:0]          out0_node1,
    output logic [OW-1:0]          out0_node2,
    output logic [OW-1:0]          out0_node3,
    output logic [OW-1:0]          out1_node0,
    output logic [OW-1:0]          out1_node1,
    output logic [OW-1:0]          out1_node2,
    output logic [OW-1:0]          out1_node3,
    output logic                   out10_ready_node0,
    output logic                   out10_ready_node1,
    output logic                   out10_ready_node2,
    output logic                   out10_ready_node3,
    output logic                   out11_ready_node0,
    output logic                   out11_ready_node1,
    output logic                   out11_ready_node2,
    output logic                   out11_ready_node3,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output sched_state_t           state
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int NW = $clog2(NODES);

    feat_vec_t                feat_q;
    logic [NODES*NODES-1:0]   adj_q;
    logic [NW-1:0]            n;
    logic [OW-1:0]            hold0;
    logic [OW-1:0]            hold1;
    logic                     got0;
    logic                     got1;
    logic                     store_en;
    logic [TW-1:0]            timer;
    logic [OW-1:0]            res0 [NODES];
    logic [OW-1:0]            res1 [NODES];
    logic [NODES-1:0]         rdy0;
    logic [NODES-1:0]         rdy1;
    logic [NODES-1:0]         row;
    logic [FEATS-1:0][AW-1:0] aggr;
    logic                     got0_nxt;
    logic                     got1_nxt;

    always_comb begin
        row      = adj_q[int'(n)*NODES +: NODES];
        got0_nxt = got0 | mac.mac_out0_ready;
        got1_nxt = got1 | mac.mac_out1_ready;
    end

    gnn_aggr u_aggr (
        .feats (feat_q),
        .row   (row),
        .aggr  (aggr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            feat_q           <= '0;
            adj_q            <= '0;
            n                <= '0;
            hold0            <= '0;
            hold1            <= '0;
            got0             <= 1'b0;
            got1             <= 1'b0;
            store_en         <= 1'b0;
            timer            <= '0;
            res0             <= '{default: '0};
            res1             <= '{default: '0};
            rdy0             <= '0;
            rdy1             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            mac.mac_x0       <= '0;
            mac.mac_x1       <= '0;
            mac.mac_x2       <= '0;
            mac.mac_x3       <= '0;
            mac.mac_in_ready <= 1'b0;
        end else begin
            mac.mac_in_ready <= 1'b0;
            done             <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        feat_q <= feat_in;
                        adj_q  <= adj;
                        res0   <= '{default: '0};
                        res1   <= '{default: '0};
                        rdy0   <= '0;
                        rdy1   <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        n      <= '0;
                        state  <= ST_AGGR;
                    end
                end
                ST_AGGR: begin
                    mac.mac_x0       <= aggr[0];
                    mac.mac_x1       <= aggr[1];
                    mac.mac_x2       <= aggr[2];
                    mac.mac_x3       <= aggr[3];
                    mac.mac_in_ready <= 1'b1;
                    state            <= ST_ISSUE;
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mac.mac_out0_ready) hold0 <= mac.mac_out0;
                    if (mac.mac_out1_ready) hold1 <= mac.mac_out1;
                    got0 <= got0_nxt;
                    got1 <= got1_nxt;
                    // A pair completing on the last allowed cycle still wins over the timeout.
                    if (got0_nxt && got1_nxt) begin
                        store_en <= 1'b1;
                        state    <= ST_STORE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        store_en <= 1'b0;
                        err      <= 1'b1;
                        state    <= ST_STORE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STORE: begin
                    if (store_en) begin
                        res0[n] <= hold0;
                        res1[n] <= hold1;
                        rdy0[n] <= 1'b1;
                        rdy1[n] <= 1'b1;
                    end
                    got0  <= 1'b0;
                    got1  <= 1'b0;
                    timer <= '0;
                    if (n == NW'(NODES - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        n     <= n + 1'b1;
                        state <= ST_AGGR;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out0_node0        = res0[0];
    assign out0_node1        = res0[1];
    assign out0_node2        = res0[2];
    assign out0_node3        = res0[3];
    assign out1_node0        = res1[0];
    assign out1_node1        = res1[1];
    assign out1_node2        = res1[2];
    assign out1_node3        = res1[3];
    assign out10_ready_node0 = rdy0[0];
    assign out10_ready_node1 = rdy0[1];
    assign out10_ready_node2 = rdy0[2];
    assign out10_ready_node3 = rdy0[3];
    assign out11_ready_node0 = rdy1[0];
    assign out11_ready_node1 = rdy1[1];
    assign out11_ready_node2 = rdy1[2];
    assign out11_ready_node3 = rdy1[3];
endmodule

// File: tb/tb_gnn_mac_scheduler.sv
// Directed bench for gnn_mac_scheduler: MAC responder model, issue/result scoreboard,
// latency, timeout and mid-frame reset scenarios.
module tb_gnn_mac_scheduler;
    import gnn_pkg::*;

    typedef struct packed {
        logic [3:0][OW-1:0] o0;
        logic [3:0][OW-1:0] o1;
        logic [3:0]         r0;
        logic [3:0]         r1;
        logic               err;
    } done_exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    feat_vec_t              feat_in;
    logic [NODES*NODES-1:0] adj;
    logic [OW-1:0]          o00, o01, o02, o03, o10, o11, o12, o13;
    logic                   r00, r01, r02, r03, r10, r11, r12, r13;
    logic                   busy, done, err;
    sched_state_t           state;

    gnn_mac_scheduler_if mif ();

    gnn_mac_scheduler #(.TIMEOUT(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .feat_in           (feat_in),
        .adj               (adj),
        .mac               (mif),
        .out0_node0        (o00),
        .out0_node1        (o01),
        .out0_node2        (o02),
        .out0_node3        (o03),
        .out1_node0        (o10),
        .out1_node1        (o11),
        .out1_node2        (o12),
        .out1_node3        (o13),
        .out10_ready_node0 (r00),
        .out10_ready_node1 (r01),
        .out10_ready_node2 (r02),
        .out10_ready_node3 (r03),
        .out11_ready_node0 (r10),
        .out11_ready_node1 (r11),
        .out11_ready_node2 (r12),
        .out11_ready_node3 (r13),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .state             (state)
    );

    always #5 clk = ~clk;

    logic [3:0][OW-1:0] act_o0, act_o1;
    logic [3:0]         act_r0, act_r1;
    logic [27:0]        act_x;
    assign act_o0 = {o03, o02, o01, o00};
    assign act_o1 = {o13, o12, o11, o10};
    assign act_r0 = {r03, r02, r01, r00};
    assign act_r1 = {r13, r12, r11, r10};
    assign act_x  = {mif.mac_x3, mif.mac_x2, mif.mac_x1, mif.mac_x0};

    int n_checks = 0;
    int n_pass   = 0;
    logic [27:0] exp_q[$];
    done_exp_t   done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // MAC responder: per issue, each result strobe fires d cycles later (0 = never).
    int          d0 [4];
    int          d1 [4];
    bit          out1_const;
    int          c0, c1, idx;
    logic [16:0] m_r0, m_r1, m_s;

    initial begin
        mif.mac_out0 = '0; mif.mac_out1 = '0;
        mif.mac_out0_ready = 1'b0; mif.mac_out1_ready = 1'b0;
        c0 = 0; c1 = 0; idx = 0; m_r0 = '0; m_r1 = '0;
        forever begin
            @(negedge clk);
            mif.mac_out0_ready = 1'b0;
            mif.mac_out1_ready = 1'b0;
            if (c0 > 0) begin
                c0--;
                if (c0 == 0) begin mif.mac_out0 = m_r0; mif.mac_out0_ready = 1'b1; end
            end
            if (c1 > 0) begin
                c1--;
                if (c1 == 0) begin mif.mac_out1 = m_r1; mif.mac_out1_ready = 1'b1; end
            end
            if (state == ST_IDLE) idx = 0;
            if (mif.mac_in_ready === 1'b1) begin
                m_s  = 17'(mif.mac_x0) + 17'(mif.mac_x1) + 17'(mif.mac_x2) + 17'(mif.mac_x3);
                m_r0 = m_s;
                m_r1 = out1_const ? 17'h1FFFF : ~m_s;
                if (idx < 4) begin c0 = d0[idx]; c1 = d1[idx]; end
                idx++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues or finishes a frame.
    initial begin
        logic [27:0] ex;
        done_exp_t   de;
        forever begin
            @(negedge clk);
            if (mif.mac_in_ready === 1'b1) begin
                check("issue_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ex = exp_q.pop_front();
                    check("mac_x", 32'(act_x), 32'(ex));
                end
            end
            if (done === 1'b1) begin
                check("done_expected", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    de = done_q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        check($sformatf("out0_node%0d", i), 32'(act_o0[i]), 32'(de.o0[i]));
                        check($sformatf("out1_node%0d", i), 32'(act_o1[i]), 32'(de.o1[i]));
                    end
                    check("out10_flags", 32'(act_r0), 32'(de.r0));
                    check("out11_flags", 32'(act_r1), 32'(de.r1));
                    check("err_at_done", 32'(err), 32'(de.err));
                end
            end
        end
    end

    function automatic feat_vec_t mk_feats(input int mode);
        feat_vec_t f;
        f = '0;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                f[(j*4+k)*5 +: 5] = (mode == 0) ? 5'd31 : (mode == 1) ? 5'(j + 1) : 5'(j*4 + k + 1);
        return f;
    endfunction

    function automatic logic [27:0] px(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_in_ready"}, 32'(mif.mac_in_ready), 0);
        check({tag, "_mac_x"}, 32'(act_x), 0);
        check({tag, "_results"}, 32'(|{act_o0, act_o1}), 0);
        check({tag, "_flags"}, 32'({act_r0, act_r1}), 0);
    endtask

    task automatic run_frame(input feat_vec_t f, input logic [15:0] a, input int exp_edges,
                             input string tag);
        int cnt;
        @(negedge clk);
        feat_in = f; adj = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 1);
        check({tag, "_err_cleared"}, 32'(err), 0);
        check({tag, "_results_cleared"}, 32'(|{act_o0, act_o1, act_r0, act_r1}), 0);
        cnt = 0;
        while (done !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(exp_edges));
        check({tag, "_busy_at_done"}, 32'(busy), 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        done_exp_t e;
        rst = 1'b1; start = 1'b0; feat_in = '0; adj = '0; out1_const = 1'b0;
        d0 = '{1, 1, 1, 1}; d1 = '{1, 1, 1, 1};
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // Fully connected, all features 31: every aggregate is 124, sum 496.
        out1_const = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(px(124, 124, 124, 124));
        e.o0 = {4{17'd496}}; e.o1 = {4{17'h1FFFF}}; e.r0 = 4'hF; e.r1 = 4'hF; e.err = 1'b0;
        done_q.push_back(e);
        run_frame(mk_feats(0), 16'hFFFF, 16, "full");

        // Self-loops only, node i features all i+1.
        out1_const = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(px(i + 1, i + 1, i + 1, i + 1));
        e.o0 = {17'd16, 17'd12, 17'd8, 17'd4};
        e.o1 = {17'h1FFFF - 17'd16, 17'h1FFFF - 17'd12, 17'h1FFFF - 17'd8, 17'h1FFFF - 17'd4};
        e.r0 = 4'hF; e.r1 = 4'hF; e.err = 1'b0;
        done_q.push_back(e);
        run_frame(mk_feats(1), 16'h8421, 16, "self");

        // Distinct features, empty row for node 1, skewed strobe timing.
        d0 = '{4, 2, 1, 1}; d1 = '{1, 2, 3, 1};
        exp_q.push_back(px(18, 20, 22, 24));
        exp_q.push_back(px(0, 0, 0, 0));
        exp_q.push_back(px(15, 18, 21, 24));
        exp_q.push_back(px(23, 26, 29, 32));
        e.o0 = {17'd110, 17'd78, 17'd0, 17'd84};
        e.o1 = {17'h1FFFF - 17'd110, 17'h1FFFF - 17'd78, 17'h1FFFF, 17'h1FFFF - 17'd84};
        e.r0 = 4'hF; e.r1 = 4'hF; e.err = 1'b0;
        done_q.push_back(e);
        run_frame(mk_feats(2), 16'hD70A, 22, "mixed");

        // Node 2 never answers: 8 WAIT cycles then timeout, node 3 still completes.
        d0 = '{1, 1, 0, 1}; d1 = '{1, 1, 0, 1};
        for (int i = 0; i < 4; i++) exp_q.push_back(px(i + 1, i + 1, i + 1, i + 1));
        e.o0 = {17'd16, 17'd0, 17'd8, 17'd4};
        e.o1 = {17'h1FFFF - 17'd16, 17'd0, 17'h1FFFF - 17'd8, 17'h1FFFF - 17'd4};
        e.r0 = 4'b1011; e.r1 = 4'b1011; e.err = 1'b1;
        done_q.push_back(e);
        run_frame(mk_feats(1), 16'h8421, 23, "timeout");
        check("err_sticky", 32'(err), 1);
        check("result_hold", 32'(o03), 16);

        // Mid-frame start with garbage inputs, then reset during node 1 WAIT.
        d0 = '{1, 5, 1, 1}; d1 = '{1, 5, 1, 1};
        exp_q.push_back(px(18, 20, 22, 24));
        exp_q.push_back(px(0, 0, 0, 0));
        @(negedge clk);
        feat_in = mk_feats(2); adj = 16'hD70A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_err_cleared", 32'(err), 0);
        check("abort_results_cleared", 32'(|{act_o0, act_o1, act_r0, act_r1}), 0);
        @(negedge clk);
        feat_in = mk_feats(0); adj = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_wait", 32'(state), 32'(ST_WAIT));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort");
        repeat (5) @(negedge clk);
        check_idle_zero("late_strobe");

        // Clean frame after the abort.
        d0 = '{1, 1, 1, 1}; d1 = '{1, 1, 1, 1};
        for (int i = 0; i < 4; i++) exp_q.push_back(px(i + 1, i + 1, i + 1, i + 1));
        e.o0 = {17'd16, 17'd12, 17'd8, 17'd4};
        e.o1 = {17'h1FFFF - 17'd16, 17'h1FFFF - 17'd12, 17'h1FFFF - 17'd8, 17'h1FFFF - 17'd4};
        e.r0 = 4'hF; e.r1 = 4'hF; e.err = 1'b0;
        done_q.push_back(e);
        run_frame(mk_feats(1), 16'h8421, 16, "clean");

        repeat (2) @(negedge clk);
        check("issue_queue_drained", 32'(exp_q.size()), 0);
        check("done_queue_drained", 32'(done_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
